// File: rtl/dsp48a1_slice_pkg.sv
// Shared constants for the DSP48A1-style slice: opmode bit positions,
// X/Z multiplexer encodings and the string values of the source-select parameters.
package dsp48a1_slice_pkg;

    localparam int OP_X_LO     = 0;
    localparam int OP_X_HI     = 1;
    localparam int OP_Z_LO     = 2;
    localparam int OP_Z_HI     = 3;
    localparam int OP_PRE_EN   = 4;
    localparam int OP_CIN      = 5;
    localparam int OP_PRE_SUB  = 6;
    localparam int OP_POST_SUB = 7;

    typedef enum logic [1:0] {
        X_ZERO = 2'd0,
        X_M    = 2'd1,
        X_P    = 2'd2,
        X_DAB  = 2'd3
    } x_sel_e;

    typedef enum logic [1:0] {
        Z_ZERO = 2'd0,
        Z_PCIN = 2'd1,
        Z_P    = 2'd2,
        Z_C    = 2'd3
    } z_sel_e;

    localparam string CIN_SEL_OPMODE5 = "OPMODE5";
    localparam string CIN_SEL_CARRYIN = "CARRYIN";
    localparam string B_IN_DIRECT     = "DIRECT";
    localparam string B_IN_CASCADE    = "CASCADE";

endpackage

// File: rtl/dsp48a1_slice_if.sv
// Data, opmode, clock-enable and result bundle of the DSP slice.
// The master side drives operands and enables; the slave side is the slice.
interface dsp48a1_slice_if;
    logic [17:0] A;
    logic [17:0] B;
    logic [17:0] BCIN;
    logic [47:0] C;
    logic [17:0] D;
    logic [47:0] PCIN;
    logic        carryin;
    logic [7:0]  opmode;
    logic        CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE;
    logic [17:0] BCOUT;
    logic [35:0] M;
    logic [47:0] P;
    logic [47:0] Pcout;
    logic        carryout;
    logic        carryoutf;

    modport master (
        output A, B, BCIN, C, D, PCIN, carryin, opmode,
        output CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE,
        input  BCOUT, M, P, Pcout, carryout, carryoutf
    );

    modport slave (
        input  A, B, BCIN, C, D, PCIN, carryin, opmode,
        input  CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE,
        output BCOUT, M, P, Pcout, carryout, carryoutf
    );
endinterface

// File: rtl/dsp48a1_slice_pipe_reg.sv
// Optional pipeline stage: a clock-enabled register with asynchronous clear,
// or a plain wire when REGISTERED is 0.
module dsp_pipe_reg #(
    parameter int W          = 18,
    parameter bit REGISTERED = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    generate
        if (REGISTERED) begin : g_reg
            // NOTE: non-blocking assignment so every stage samples the pre-edge value of its neighbour.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)     q <= '0;
                else if (ce) q <= d;
            end
        end else begin : g_bypass
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst, ce};
            assign q = d;
        end
    endgenerate
endmodule

// File: rtl/dsp48a1_slice.sv
// DSP48A1-style slice: 18-bit pre-adder, 18x18 unsigned multiplier and 48-bit
// post-adder/accumulator, each stage with an optional register.
module dsp48a1_slice
    import dsp48a1_slice_pkg::*;
#(
    parameter int    A0REG       = 0,
    parameter int    A1REG       = 1,
    parameter int    B0REG       = 0,
    parameter int    B1REG       = 1,
    parameter int    CREG        = 1,
    parameter int    DREG        = 1,
    parameter int    MREG        = 1,
    parameter int    PREG        = 1,
    parameter int    CARRYINREG  = 1,
    parameter int    CARRYOUTREG = 1,
    parameter int    OPMODEREG   = 1,
    parameter string CARRYINSEL  = CIN_SEL_OPMODE5,
    parameter string B_INPUT     = B_IN_DIRECT
) (
    input logic             clk,
    input logic             RSTA,
    input logic             RSTB,
    input logic             RSTC,
    input logic             RSTD,
    input logic             RSTM,
    input logic             RSTP,
    input logic             RSCARRYIN,
    input logic             RSTopmode,
    dsp48a1_slice_if.slave  bus
);
    logic [17:0] a0, a1, b0_in, b0, b1_in, b1, d_r, pre_sum;
    logic [47:0] c_r, p_r, x_mux, z_mux;
    logic [35:0] m_in, m_r;
    logic [7:0]  op_r;
    logic        cin_in, cin_r, co_r;
    logic [48:0] post_sum;

    assign b0_in  = (B_INPUT == B_IN_CASCADE) ? bus.BCIN : bus.B;
    assign cin_in = (CARRYINSEL == CIN_SEL_CARRYIN) ? bus.carryin : op_r[OP_CIN];

    dsp_pipe_reg #(.W(8),  .REGISTERED(OPMODEREG != 0)) u_op (.clk, .rst(RSTopmode), .ce(bus.CEOPMODE), .d(bus.opmode), .q(op_r));
    dsp_pipe_reg #(.W(18), .REGISTERED(A0REG != 0))     u_a0 (.clk, .rst(RSTA), .ce(bus.CEA), .d(bus.A), .q(a0));
    dsp_pipe_reg #(.W(18), .REGISTERED(A1REG != 0))     u_a1 (.clk, .rst(RSTA), .ce(bus.CEA), .d(a0), .q(a1));
    dsp_pipe_reg #(.W(18), .REGISTERED(B0REG != 0))     u_b0 (.clk, .rst(RSTB), .ce(bus.CEB), .d(b0_in), .q(b0));
    dsp_pipe_reg #(.W(18), .REGISTERED(B1REG != 0))     u_b1 (.clk, .rst(RSTB), .ce(bus.CEB), .d(b1_in), .q(b1));
    dsp_pipe_reg #(.W(48), .REGISTERED(CREG != 0))      u_c  (.clk, .rst(RSTC), .ce(bus.CEC), .d(bus.C), .q(c_r));
    dsp_pipe_reg #(.W(18), .REGISTERED(DREG != 0))      u_d  (.clk, .rst(RSTD), .ce(bus.CED), .d(bus.D), .q(d_r));
    dsp_pipe_reg #(.W(36), .REGISTERED(MREG != 0))      u_m  (.clk, .rst(RSTM), .ce(bus.CEM), .d(m_in), .q(m_r));
    dsp_pipe_reg #(.W(1),  .REGISTERED(CARRYINREG != 0)) u_cin (.clk, .rst(RSCARRYIN), .ce(bus.CECARRYIN), .d(cin_in), .q(cin_r));
    dsp_pipe_reg #(.W(48), .REGISTERED(PREG != 0))      u_p  (.clk, .rst(RSTP), .ce(bus.CEP), .d(post_sum[47:0]), .q(p_r));
    dsp_pipe_reg #(.W(1),  .REGISTERED(CARRYOUTREG != 0)) u_co (.clk, .rst(RSTP), .ce(bus.CEP), .d(post_sum[48]), .q(co_r));

    // Pre-adder wraps at 18 bits; it only reaches B1 when the pre-adder enable bit is set.
    assign pre_sum = op_r[OP_PRE_SUB] ? (d_r - b0) : (d_r + b0);
    assign b1_in   = op_r[OP_PRE_EN] ? pre_sum : b0;
    assign m_in    = 36'(a1) * 36'(b1);

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        x_mux    = '0;
        z_mux    = '0;
        post_sum = '0;
        case (x_sel_e'(op_r[OP_X_HI:OP_X_LO]))
            X_ZERO: x_mux = '0;
            X_M:    x_mux = {12'd0, m_r};
            X_P:    x_mux = p_r;
            X_DAB:  x_mux = {d_r[11:0], a1, b1};
            default: x_mux = '0;
        endcase
        case (z_sel_e'(op_r[OP_Z_HI:OP_Z_LO]))
            Z_ZERO: z_mux = '0;
            Z_PCIN: z_mux = bus.PCIN;
            Z_P:    z_mux = p_r;
            Z_C:    z_mux = c_r;
            default: z_mux = '0;
        endcase
        // Bit 48 is the carry on add and the borrow on subtract.
        if (op_r[OP_POST_SUB])
            post_sum = {1'b0, z_mux} - ({1'b0, x_mux} + 49'(cin_r));
        else
            post_sum = {1'b0, z_mux} + {1'b0, x_mux} + 49'(cin_r);
    end

    assign bus.BCOUT     = b1;
    assign bus.M         = m_r;
    assign bus.P         = p_r;
    assign bus.Pcout     = p_r;
    assign bus.carryout  = co_r;
    assign bus.carryoutf = co_r;
endmodule

// File: tb/tb_dsp48a1_slice.sv
// Scoreboard bench for dsp48a1_slice with default parameters: a step model
// predicts the registered outputs for every clock, a monitor compares them.
module tb_dsp48a1_slice;
    logic clk = 1'b0;
    logic RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSCARRYIN, RSTopmode;
    always #5 clk = ~clk;

    dsp48a1_slice_if bus ();

    dsp48a1_slice dut (
        .clk(clk), .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD),
        .RSTM(RSTM), .RSTP(RSTP), .RSCARRYIN(RSCARRYIN), .RSTopmode(RSTopmode),
        .bus(bus)
    );

    typedef struct {
        logic [17:0] a, b, bcin, d;
        logic [47:0] c, pcin;
        logic [7:0]  op;
        logic        cin;
    } stim_t;

    typedef struct {
        logic [17:0] bcout;
        logic [35:0] m;
        logic [47:0] p;
        logic        co;
    } exp_t;

    exp_t  sb_q[$];
    exp_t  mon_e;
    int    checks = 0;
    int    failures = 0;

    // Model history: inputs of the previous enabled step, opmode two steps back,
    // and the values the slice holds after the previous enabled step.
    stim_t prev;
    logic [7:0]  prev2_op;
    exp_t  cur;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s.a    = 18'($urandom);
        s.b    = 18'($urandom);
        s.bcin = 18'($urandom);
        s.d    = 18'($urandom);
        s.c    = 48'({$urandom, $urandom});
        s.pcin = 48'({$urandom, $urandom});
        s.op   = 8'($urandom);
        s.cin  = 1'($urandom);
        return s;
    endfunction

    task automatic apply(input stim_t s);
        bus.A = s.a; bus.B = s.b; bus.BCIN = s.bcin; bus.D = s.d;
        bus.C = s.c; bus.PCIN = s.pcin; bus.opmode = s.op; bus.carryin = s.cin;
    endtask

    task automatic set_ce(input logic [7:0] ce);
        {bus.CEA, bus.CEB, bus.CEC, bus.CED, bus.CEM, bus.CEP, bus.CECARRYIN, bus.CEOPMODE} = ce;
    endtask

    task automatic set_rst(input logic v);
        {RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSCARRYIN, RSTopmode} = {8{v}};
    endtask

    function automatic void model_reset();
        prev = '{default: '0};
        prev2_op = '0;
        cur = '{default: '0};
    endfunction

    // One enabled clock: opmode takes effect one step after it is applied, the
    // carry-in bit one step later still; B feeds the pre-adder unregistered.
    task automatic model_step(input stim_t s);
        logic [17:0] pre, b1_new;
        logic [35:0] m_new;
        logic [47:0] x, z;
        logic [48:0] res;
        logic        cy;
        pre    = prev.op[6] ? 18'(prev.d - s.b) : 18'(prev.d + s.b);
        b1_new = prev.op[4] ? pre : s.b;
        m_new  = 36'(prev.a) * 36'(cur.bcout);
        cy     = prev2_op[5];
        case (prev.op[1:0])
            2'd0: x = 48'd0;
            2'd1: x = 48'(cur.m);
            2'd2: x = cur.p;
            default: x = {prev.d[11:0], prev.a, cur.bcout};
        endcase
        case (prev.op[3:2])
            2'd0: z = 48'd0;
            2'd1: z = s.pcin;
            2'd2: z = cur.p;
            default: z = prev.c;
        endcase
        if (prev.op[7]) res = {1'b0, z} - ({1'b0, x} + 49'(cy));
        else            res = {1'b0, z} + {1'b0, x} + 49'(cy);
        prev2_op  = prev.op;
        prev      = s;
        cur.bcout = b1_new;
        cur.m     = m_new;
        cur.p     = res[47:0];
        cur.co    = res[48];
    endtask

    // Drive one cycle at the falling edge and queue what the next rising edge must produce.
    task automatic step(input stim_t s, input bit freeze);
        @(negedge clk);
        apply(s);
        set_ce(freeze ? 8'h00 : 8'hFF);
        if (!freeze) model_step(s);
        sb_q.push_back(cur);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("BCOUT",     48'(bus.BCOUT),     48'(mon_e.bcout));
            check("M",         48'(bus.M),         48'(mon_e.m));
            check("P",         bus.P,              mon_e.p);
            check("Pcout",     bus.Pcout,          mon_e.p);
            check("carryout",  48'(bus.carryout),  48'(mon_e.co));
            check("carryoutf", 48'(bus.carryoutf), 48'(mon_e.co));
        end
    end

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        stim_t s;
        set_rst(1'b1);
        model_reset();
        apply(rand_stim());
        set_ce(8'($urandom));

        // Resets held: everything reads zero whatever the data and enables do.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            apply(rand_stim());
            set_ce(8'($urandom));
            sb_q.push_back(cur);
        end

        // Resets released with all enables low: registers keep their cleared value.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            set_rst(1'b0);
            apply(rand_stim());
            set_ce(8'h00);
            sb_q.push_back(cur);
        end

        s = '{a: 18'd0, b: 18'd2, bcin: 18'h3_FFFF, d: 18'd7, c: 48'd5,
              pcin: 48'd75, op: 8'h3D, cin: 1'b0};
        for (int i = 0; i < 6; i++) step(s, 1'b0);
        settle();
        check("t3_BCOUT", 48'(bus.BCOUT), 48'd9);
        check("t3_M",     48'(bus.M),     48'd0);
        check("t3_P",     bus.P,          48'd6);
        check("t3_co",    48'(bus.carryout), 48'd0);

        s.op = 8'h03; s.cin = 1'b1;
        for (int i = 0; i < 6; i++) step(s, 1'b0);
        settle();
        check("t4_P",     bus.P,          48'h70_0000_0002);
        check("t4_BCOUT", 48'(bus.BCOUT), 48'd2);
        check("t4_co",    48'(bus.carryout), 48'd0);

        s.op = 8'h9A;
        for (int i = 0; i < 6; i++) step(s, 1'b0);
        settle();
        check("t5_P",     bus.P,          48'd0);
        check("t5_co",    48'(bus.carryout), 48'd0);
        check("t5_BCOUT", 48'(bus.BCOUT), 48'd9);

        s.op = 8'hA5;
        for (int i = 0; i < 6; i++) step(s, 1'b0);
        settle();
        check("t6_P",     bus.P,          48'd74);
        check("t6_M",     48'(bus.M),     48'd0);
        check("t6_co",    48'(bus.carryout), 48'd0);

        // Random operation mix with occasional cycles where every enable is low.
        for (int i = 0; i < 300; i++) step(rand_stim(), ($urandom_range(0, 4) == 0));

        settle();
        check("scoreboard_drained", 48'(sb_q.size()), 48'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
